sync_clk_xgmii_tx_filt: RTL and testbench
=========================================

# sync_clk_xgmii_tx_filt

Parametrised multi-channel synchroniser for signals entering the XGMII transmit clock domain. Successor to the fixed 3-bit TX control/status sync. Adds:
- configurable synchroniser depth;
- a per-channel stability filter (debounce);
- registered rise/fall pulses;
- sticky event latches with per-channel clear;
- a toggle mode that turns each source-domain toggle into a single-cycle pulse.

It sits between the RX-clock fault detector and CPU-clock control registers on one side and the TX state machine and fault handling on the other.

## Interface
Parameters:
- CHANNELS, 3, number of synchronised bits (min 1)
- SYNC_STAGES, 2, flip-flops in each metastability chain (min 2)
- FILT_CYCLES, 4, consecutive stable cycles required before a level output changes (min 1)
- TOGGLE_MASK, '0, CHANNELS-bit mask; bit i = 1 puts channel i in toggle mode

Ports:
- clk_xgmii_tx  input  1  XGMII TX clock; the only clock.
- reset_xgmii_tx_n  input  1  Reset, asynchronous assert, active-low.
- in_async  input  CHANNELS  Asynchronous inputs: level signals, or toggle signals for toggle-mode channels.
- clear_sticky  input  CHANNELS  Synchronous, per-channel clear of sticky_out.
- level_out  output  CHANNELS  Filtered, synchronised level.
- rise_pulse  output  CHANNELS  One-cycle pulse on a 0→1 change of level_out; in toggle mode, one pulse per toggle.
- fall_pulse  output  CHANNELS  One-cycle pulse on a 1→0 change of level_out; always 0 in toggle mode.
- sticky_out  output  CHANNELS  Latched event: set by rise_pulse, cleared by clear_sticky.

## Operation
- Synchronisation:
  - Each channel passes in_async[i] through a SYNC_STAGES flop chain.
  - s[i] denotes the chain's last stage.
- Level mode, TOGGLE_MASK[i] = 0:
  - Counter cnt[i] is $clog2(FILT_CYCLES+1) bits wide.
  - When s[i] == level_out[i], cnt clears to 0.
  - Otherwise cnt increments. On the edge where cnt == FILT_CYCLES-1 with s[i] still differing, level_out[i] takes s[i] and cnt clears.
  - Any return of s[i] to level_out[i] before that edge discards the change (glitch rejected).
  - rise_pulse/fall_pulse are registered and assert in the same cycle level_out changes, for exactly one cycle.
- Toggle mode, TOGGLE_MASK[i] = 1:
  - No filter; cnt is unused.
  - level_out[i] is the registered s[i].
  - rise_pulse[i] = 1 for one cycle whenever s[i] differs from the registered previous value, in either direction. fall_pulse[i] = 0.
  - Toggles spaced closer than SYNC_STAGES+1 clk_xgmii_tx cycles are a source-side protocol violation; no merging or detection is required.
- Sticky latch:
  - sticky_out[i] sets on rise_pulse[i] and clears when clear_sticky[i] = 1.
  - Set and clear in the same cycle: set wins, sticky stays 1.
- Channels are fully independent; there is no cross-channel coherency guarantee.

## Timing
- Reset: all sync flops, cnt, level_out, rise_pulse, fall_pulse and sticky_out go to 0 immediately on assertion.
- After deassertion, the first valid sample is taken on the next clk_xgmii_tx edge.
- An input held at 1 through reset behaves as a 0→1 change:
  - it produces a rise_pulse after full latency;
  - fault inputs therefore set sticky_out after reset.
- Level-mode latency: in_async is stable before edge 0. s changes after SYNC_STAGES edges. level_out and pulse change FILT_CYCLES edges later, for a total of SYNC_STAGES+FILT_CYCLES edges.
- FILT_CYCLES = 1 gives SYNC_STAGES+1.
- Toggle-mode latency: SYNC_STAGES+1 edges from toggle to rise_pulse.
- sticky_out is 1 on the edge after rise_pulse. clear_sticky takes effect on the next edge.
- Reset mid-filter: the pending change is discarded and the count restarts from 0.

## Structure
- Package xge_sync_pkg:
  - function filt_cnt_w(FILT_CYCLES);
  - localparam for the default TX channel map: bit 2 ctrl_tx_enable, bit 1 local fault, bit 0 remote fault;
  - default TOGGLE_MASK constant.
- Sub-module sync_filt_chan:
  - contains one channel's sync chain, filter counter, pulse registers and sticky latch;
  - parameters SYNC_STAGES, FILT_CYCLES, TOGGLE;
  - the top level instantiates it with a generate loop over CHANNELS.

## Test plan
All tests use defaults (CHANNELS=3, SYNC_STAGES=2, FILT_CYCLES=4, TOGGLE_MASK=0) unless stated.
- Step in_async[1] 0→1 at edge 0:
  - level_out[1] = 1 and rise_pulse[1] = 1 at edge 6 only;
  - sticky_out[1] = 1 from edge 7.
- Glitch: in_async[0] = 1 for 3 cycles, then 0 → level_out[0], rise_pulse[0] and sticky_out[0] stay 0. The same input held for 4 cycles (after sync) → change accepted.
- Sticky clear/set collision: clear_sticky[2] = 1 on the same edge as rise_pulse[2] → sticky_out[2] stays 1. A clear on a later edge → sticky_out[2] = 0 next cycle.
- Toggle mode, TOGGLE_MASK = 3'b001: four toggles of in_async[0], spaced 5 cycles apart → exactly 4 rise_pulse[0], each 3 edges after its toggle; fall_pulse[0] is never 1.
- Reset mid-filter: assert reset_xgmii_tx_n = 0 at edge 4 of a pending 0→1 change → all outputs 0 immediately. After release with the input held at 1 → rise at edge 6 after release.
- Parameter sweep (SYNC_STAGES=3, FILT_CYCLES=1): step input → level_out changes at edge 4.

Source files
------------

// File: rtl/xge_sync_pkg.sv
// Shared definitions for the XGMII TX-domain synchroniser: filter counter sizing,
// the default TX channel map and the default toggle-mode mask.
package xge_sync_pkg;

  localparam int TX_CHANNELS          = 3;
  localparam int CH_REMOTE_FAULT      = 0;
  localparam int CH_LOCAL_FAULT       = 1;
  localparam int CH_CTRL_TX_ENABLE    = 2;

  // All default TX channels are level signals.
  localparam logic [TX_CHANNELS-1:0] TX_TOGGLE_MASK_DEFAULT = '0;

  function automatic int filt_cnt_w(input int filt_cycles);
    return $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_filt_chan.sv
// One synchronised channel: metastability chain, stability filter (or toggle
// detector), registered rise/fall pulses and a sticky event latch.
module sync_filt_chan
  import xge_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter bit TOGGLE      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_async,
  input  logic clear_sticky,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic sticky_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sticky_q, sticky_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_async};
  assign s      = sync_q[SYNC_STAGES-1];

  if (TOGGLE) begin : g_toggle
    // Every change of the synchronised toggle is an event; no filtering.
    always_comb begin
      level_d = s;
      rise_d  = s ^ level_q;
      fall_d  = 1'b0;
    end
  end else begin : g_level
    localparam int CW = filt_cnt_w(FILT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A change is accepted only after FILT_CYCLES consecutive differing samples;
    // any agreeing sample restarts the count.
    always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      cnt_d   = '0;
      if (s != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Set has priority over clear so an event coinciding with a clear is not lost.
  assign sticky_d = rise_q | (sticky_q & ~clear_sticky);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign sticky_out = sticky_q;

endmodule

// File: rtl/sync_clk_xgmii_tx_filt.sv
// Multi-channel synchroniser into the XGMII TX clock domain; each bit is an
// independent sync_filt_chan, in level or toggle mode per TOGGLE_MASK.
module sync_clk_xgmii_tx_filt
  import xge_sync_pkg::*;
#(
  parameter int                  CHANNELS    = TX_CHANNELS,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILT_CYCLES = 4,
  parameter logic [CHANNELS-1:0] TOGGLE_MASK = '0
) (
  input  logic                clk_xgmii_tx,
  input  logic                reset_xgmii_tx_n,
  input  logic [CHANNELS-1:0] in_async,
  input  logic [CHANNELS-1:0] clear_sticky,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] sticky_out
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sync_filt_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .TOGGLE      (TOGGLE_MASK[i])
    ) u_chan (
      .clk          (clk_xgmii_tx),
      .rst_n        (reset_xgmii_tx_n),
      .in_async     (in_async[i]),
      .clear_sticky (clear_sticky[i]),
      .level_out    (level_out[i]),
      .rise_pulse   (rise_pulse[i]),
      .fall_pulse   (fall_pulse[i]),
      .sticky_out   (sticky_out[i])
    );
  end

endmodule

// File: tb/tb_sync_clk_xgmii_tx_filt.sv
// Bench for sync_clk_xgmii_tx_filt: three instances (defaults, toggle ch0,
// SYNC_STAGES=3/FILT_CYCLES=1) share stimulus and are checked against a history model.
module tb_sync_clk_xgmii_tx_filt;

  logic       clk;
  logic       rst_n = 1'b1;
  logic [2:0] in_async = '0;
  logic [2:0] clear_sticky = '0;
  logic [2:0] lvl_o[3];
  logic [2:0] rise_o[3];
  logic [2:0] fall_o[3];
  logic [2:0] st_o[3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sync_clk_xgmii_tx_filt u_dut_a (
    .clk_xgmii_tx(clk), .reset_xgmii_tx_n(rst_n), .in_async(in_async),
    .clear_sticky(clear_sticky), .level_out(lvl_o[0]), .rise_pulse(rise_o[0]),
    .fall_pulse(fall_o[0]), .sticky_out(st_o[0]));

  sync_clk_xgmii_tx_filt #(.TOGGLE_MASK(3'b001)) u_dut_b (
    .clk_xgmii_tx(clk), .reset_xgmii_tx_n(rst_n), .in_async(in_async),
    .clear_sticky(clear_sticky), .level_out(lvl_o[1]), .rise_pulse(rise_o[1]),
    .fall_pulse(fall_o[1]), .sticky_out(st_o[1]));

  sync_clk_xgmii_tx_filt #(.SYNC_STAGES(3), .FILT_CYCLES(1)) u_dut_c (
    .clk_xgmii_tx(clk), .reset_xgmii_tx_n(rst_n), .in_async(in_async),
    .clear_sticky(clear_sticky), .level_out(lvl_o[2]), .rise_pulse(rise_o[2]),
    .fall_pulse(fall_o[2]), .sticky_out(st_o[2]));

  // ---------------- model ----------------
  // hist holds the input sampled at each edge since reset; the synchronised
  // value after edge m is the sample taken SYNC_STAGES-1 edges earlier.
  bit         hist[3][3][$];
  logic [2:0] exp_lvl[3]  = '{3'b0, 3'b0, 3'b0};
  logic [2:0] exp_rise[3] = '{3'b0, 3'b0, 3'b0};
  logic [2:0] exp_fall[3] = '{3'b0, 3'b0, 3'b0};
  logic [2:0] exp_st[3]   = '{3'b0, 3'b0, 3'b0};
  int         n_edges = 0;

  function automatic int sync_of(input int inst);
    return (inst == 2) ? 3 : 2;
  endfunction

  function automatic int filt_of(input int inst);
    return (inst == 2) ? 1 : 4;
  endfunction

  function automatic bit toggle_of(input int inst, input int ch);
    return (inst == 1) && (ch == 0);
  endfunction

  function automatic bit s_at(input int inst, input int ch, input int m);
    int idx;
    idx = m - sync_of(inst);
    if (idx < 0 || idx >= hist[inst][ch].size()) return 1'b0;
    return hist[inst][ch][idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edges = 0;
      for (int i = 0; i < 3; i++) begin
        exp_lvl[i] = '0; exp_rise[i] = '0; exp_fall[i] = '0; exp_st[i] = '0;
        for (int c = 0; c < 3; c++) hist[i][c].delete();
      end
    end else begin
      n_edges++;
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 3; c++) begin
          bit nl, nr, nf, all_diff;
          hist[i][c].push_back(in_async[c]);
          exp_st[i][c] = exp_rise[i][c] | (exp_st[i][c] & ~clear_sticky[c]);
          if (toggle_of(i, c)) begin
            nl = s_at(i, c, n_edges - 1);
            nr = s_at(i, c, n_edges - 1) ^ s_at(i, c, n_edges - 2);
            nf = 1'b0;
          end else begin
            all_diff = 1'b1;
            for (int j = 1; j <= filt_of(i); j++)
              if (s_at(i, c, n_edges - j) == exp_lvl[i][c]) all_diff = 1'b0;
            nl = all_diff ? ~exp_lvl[i][c] : exp_lvl[i][c];
            nr = all_diff & nl;
            nf = all_diff & ~nl;
          end
          exp_lvl[i][c]  = nl;
          exp_rise[i][c] = nr;
          exp_fall[i][c] = nf;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_level_u%0d", i), lvl_o[i],  exp_lvl[i]);
        chk($sformatf("model_rise_u%0d", i),  rise_o[i], exp_rise[i]);
        chk($sformatf("model_fall_u%0d", i),  fall_o[i], exp_fall[i]);
        chk($sformatf("model_sticky_u%0d", i), st_o[i],  exp_st[i]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_level_u%0d", name, i),  lvl_o[i],  3'b000);
      chk($sformatf("%s_rise_u%0d", name, i),   rise_o[i], 3'b000);
      chk($sformatf("%s_fall_u%0d", name, i),   fall_o[i], 3'b000);
      chk($sformatf("%s_sticky_u%0d", name, i), st_o[i],   3'b000);
    end
  endtask

  initial begin
    int pulses;
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1 chk_all_zero("reset_state");
    ticks(3);
    rst_n = 1'b1;
    ticks(8);

    // Step on ch1: level/rise at edge 6 (edge 4 for SYNC=3,FILT=1), sticky from edge 7.
    in_async[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("step_level_e%0d", k),  lvl_o[0][1],  (k >= 6));
      chk($sformatf("step_rise_e%0d", k),   rise_o[0][1], (k == 6));
      chk($sformatf("step_sticky_e%0d", k), st_o[0][1],   (k >= 7));
      chk($sformatf("sweep_level_e%0d", k), lvl_o[2][1],  (k >= 4));
      chk($sformatf("sweep_rise_e%0d", k),  rise_o[2][1], (k == 4));
    end
    clear_sticky[1] = 1'b1;
    tick();
    clear_sticky[1] = 1'b0;
    chk("step_sticky_cleared", st_o[0][1], 1'b0);
    in_async[1] = 1'b0;
    ticks(10);

    // Glitch on ch0: three cycles high is rejected.
    in_async[0] = 1'b1;
    ticks(3);
    in_async[0] = 1'b0;
    for (int k = 4; k <= 10; k++) begin
      tick();
      chk($sformatf("glitch_level_e%0d", k),  lvl_o[0][0],  1'b0);
      chk($sformatf("glitch_rise_e%0d", k),   rise_o[0][0], 1'b0);
      chk($sformatf("glitch_sticky_e%0d", k), st_o[0][0],   1'b0);
    end

    // Four cycles high is accepted: level 1 over edges 6..9, fall at edge 10.
    in_async[0] = 1'b1;
    ticks(4);
    in_async[0] = 1'b0;
    for (int k = 5; k <= 11; k++) begin
      tick();
      chk($sformatf("held_level_e%0d", k), lvl_o[0][0],  (k >= 6 && k <= 9));
      chk($sformatf("held_rise_e%0d", k),  rise_o[0][0], (k == 6));
      chk($sformatf("held_fall_e%0d", k),  fall_o[0][0], (k == 10));
    end
    ticks(6);

    // Sticky collision on ch2: clear sampled on the rise edge, then a later clear.
    in_async[2] = 1'b1;
    ticks(6);
    chk("coll_rise", rise_o[0][2], 1'b1);
    clear_sticky[2] = 1'b1;
    tick();
    clear_sticky[2] = 1'b0;
    chk("coll_sticky_set_wins", st_o[0][2], 1'b1);
    tick();
    chk("coll_sticky_held", st_o[0][2], 1'b1);
    clear_sticky[2] = 1'b1;
    tick();
    clear_sticky[2] = 1'b0;
    chk("coll_sticky_cleared", st_o[0][2], 1'b0);
    ticks(4);

    // Toggle mode on instance b ch0: four toggles 5 cycles apart.
    pulses = 0;
    for (int t = 0; t < 4; t++) begin
      in_async[0] = ~in_async[0];
      for (int k = 1; k <= 5; k++) begin
        tick();
        chk($sformatf("tog%0d_rise_e%0d", t, k), rise_o[1][0], (k == 3));
        chk($sformatf("tog%0d_fall_e%0d", t, k), fall_o[1][0], 1'b0);
        if (rise_o[1][0] === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL tog_pulse_count actual=%0d required=4", pulses);
    end
    ticks(10);

    // Reset mid-filter on ch1, then the held input rises 6 edges after release.
    in_async[1] = 1'b1;
    ticks(4);
    rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    ticks(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("rel_level_e%0d", k),  lvl_o[0][1],  (k >= 6));
      chk($sformatf("rel_rise_e%0d", k),   rise_o[0][1], (k == 6));
      chk($sformatf("rel_sticky_e%0d", k), st_o[0][1],   (k >= 7));
    end
    ticks(4);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
